// File: rtl/data_mem_mmio.sv
// rtl/data_mem_mmio.sv - data-side memory responder: word RAM plus GPIO, TX FIFO, status and cycle counter MMIO page
// Optional feature macro: MEMIO_CYCLE_COUNTER_EN (builds the CYCLE register at 0xFFFF_000C)
module data_mem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_err
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;

  localparam logic [29:0] WA_GPIO   = 30'h3FFF_C000;
  localparam logic [29:0] WA_TX     = 30'h3FFF_C001;
  localparam logic [29:0] WA_STATUS = 30'h3FFF_C002;

  logic [31:0] ram [RAM_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic [FW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic [29:0] word_addr;
  logic        sel_ram, sel_gpio, sel_tx, sel_stat, mapped;
  logic        wr_en, push, pop, fifo_full, fifo_empty, push_ok, push_drop;
  logic        unused_low;

  assign word_addr  = ALUResult[31:2];
  assign unused_low = ^ALUResult[1:0];

  assign sel_ram  = (ALUResult[31:AW+2] == '0);
  assign sel_gpio = (word_addr == WA_GPIO);
  assign sel_tx   = (word_addr == WA_TX);
  assign sel_stat = (word_addr == WA_STATUS);

`ifdef MEMIO_CYCLE_COUNTER_EN
  localparam logic [29:0] WA_CYCLE = 30'h3FFF_C003;
  logic [31:0] cycle_cnt;
  logic        sel_cyc;
  assign sel_cyc = (word_addr == WA_CYCLE);
  assign mapped  = sel_ram | sel_gpio | sel_tx | sel_stat | sel_cyc;
`else
  assign mapped  = sel_ram | sel_gpio | sel_tx | sel_stat;
`endif

  // Writes are suppressed while reset is asserted so a reset cycle never stores anything.
  assign wr_en      = MemWrite & reset;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign tx_valid   = ~fifo_empty;
  assign tx_data    = fifo_mem[rd_ptr];
  assign pop        = tx_valid & tx_ready;
  assign push       = wr_en & sel_tx;
  assign push_ok    = push & (~fifo_full | pop);
  assign push_drop  = push & fifo_full & ~pop;

  always_comb begin
    ReadData = 32'h0;
    if (sel_ram)
      ReadData = ram[ALUResult[AW+1:2]];
    else if (sel_gpio)
      ReadData = gpio_out;
    else if (sel_stat)
      ReadData = {16'h0, 8'(count), 5'h0, overflow, fifo_full, fifo_empty};
`ifdef MEMIO_CYCLE_COUNTER_EN
    else if (sel_cyc)
      ReadData = cycle_cnt;
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_en && sel_ram)
      ram[ALUResult[AW+1:2]] <= WriteData;
    if (push_ok)
      fifo_mem[wr_ptr] <= WriteData[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gpio_out <= 32'h0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      if (MemWrite && sel_gpio)
        gpio_out <= WriteData;
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear leaves overflow set.
      if (push_drop)
        overflow <= 1'b1;
      else if (MemWrite && sel_stat && WriteData[2])
        overflow <= 1'b0;
      if (MemWrite && !mapped)
        bus_err <= 1'b1;
    end
  end

`ifdef MEMIO_CYCLE_COUNTER_EN
  always_ff @(posedge clk) begin
    if (!reset)
      cycle_cnt <= 32'h0;
    else if (MemWrite && sel_cyc)
      cycle_cnt <= WriteData;
    else
      cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_data_mem_mmio.sv
// tb/tb_data_mem_mmio.sv - self-checking bench for data_mem_mmio against a queue/array reference model
module tb_data_mem_mmio;

  localparam int RW = 64;
  localparam int FD = 8;
  localparam logic [31:0] A_GPIO = 32'hFFFF_0000;
  localparam logic [31:0] A_TX   = 32'hFFFF_0004;
  localparam logic [31:0] A_STAT = 32'hFFFF_0008;
  localparam logic [31:0] A_CYC  = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] alu_result = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic [31:0] gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        bus_err;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_ram [RW];
  bit          m_ramv [RW];
  logic [31:0] m_gpio, m_cyc;
  logic [7:0]  m_q [$];
  bit          m_ovf, m_berr;

  data_mem_mmio #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .MemWrite(mem_write), .ALUResult(alu_result),
    .WriteData(write_data), .ReadData(read_data), .gpio_out(gpio_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cyc_mapped();
`ifdef MEMIO_CYCLE_COUNTER_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Expected load value for address a from the model; known=0 for never-written RAM.
  function automatic logic [31:0] exp_read(input logic [31:0] a, output bit known);
    logic [31:0] w;
    known = 1'b1;
    w = {a[31:2], 2'b00};
    if (w < RW * 4) begin
      known = m_ramv[w[7:2]];
      return m_ram[w[7:2]];
    end
    if (w == A_GPIO) return m_gpio;
    if (w == A_STAT)
      return {16'h0, 8'(m_q.size()), 5'h0, m_ovf, m_q.size() == FD, m_q.size() == 0};
    if (w == A_CYC && cyc_mapped()) return m_cyc;
    return 32'h0;
  endfunction

  function automatic void model_edge();
    logic [31:0] w;
    bit popped;
    w = {alu_result[31:2], 2'b00};
    if (!reset) begin
      m_gpio = 0; m_q.delete(); m_ovf = 0; m_cyc = 0; m_berr = 0;
      return;
    end
    popped = (m_q.size() != 0) && tx_ready;
    if (popped) void'(m_q.pop_front());
    m_cyc = m_cyc + 1;
    if (mem_write) begin
      if (w < RW * 4) begin
        m_ram[w[7:2]] = write_data; m_ramv[w[7:2]] = 1'b1;
      end else if (w == A_GPIO) m_gpio = write_data;
      else if (w == A_TX) begin
        if (m_q.size() < FD) m_q.push_back(write_data[7:0]);
        else m_ovf = 1'b1;
      end else if (w == A_STAT) begin
        if (write_data[2] && !(m_q.size() == FD && !popped)) m_ovf = 1'b0;
      end else if (w == A_CYC && cyc_mapped()) m_cyc = write_data;
      else m_berr = 1'b1;
    end
  endfunction

  // Drive one cycle of inputs, advance past the edge and update the model.
  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic rdy, input logic rst);
    mem_write = we; alu_result = a; write_data = d; tx_ready = rdy; reset = rst;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    mem_write = 1'b0; alu_result = a;
    #1;
    chk(name, read_data, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit known;
      logic [31:0] e;
      e = exp_read(alu_result, known);
      if (known) chk("read_data", read_data, e);
      chk("gpio_out", gpio_out, m_gpio);
      chk("tx_valid", {31'h0, tx_valid}, {31'h0, m_q.size() != 0});
      if (m_q.size() != 0) chk("tx_data", {24'h0, tx_data}, {24'h0, m_q[0]});
      chk("bus_err", {31'h0, bus_err}, {31'h0, m_berr});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < RW; i++) m_ramv[i] = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_gpio", gpio_out, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    peek("rst_status", A_STAT, 32'h0000_0001);

    cyc(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1);
    peek("ram_rd_0x13", 32'h0000_0013, 32'hDEAD_BEEF);
    cyc(1, A_GPIO, 32'h5A, 0, 1);
    chk("gpio_5a", gpio_out, 32'h0000_005A);

    for (int i = 1; i <= 9; i++) cyc(1, A_TX, i, 0, 1);
    peek("status_full_ovf", A_STAT, 32'h0000_0806);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_valid", {31'h0, tx_valid}, 32'h1);
      chk("drain_byte", {24'h0, tx_data}, i);
      cyc(0, 0, 0, 1, 1);
    end
    chk("drain_empty", {31'h0, tx_valid}, 32'h0);

    cyc(1, A_STAT, 32'h4, 0, 1);
    peek("ovf_cleared", A_STAT, 32'h0000_0001);

    for (int i = 0; i < 8; i++) cyc(1, A_TX, 32'h10 + i, 0, 1);
    cyc(1, A_TX, 32'hAA, 1, 1);
    peek("full_push_pop", A_STAT, 32'h0000_0802);
    for (int i = 0; i < 8; i++) begin
      chk("pp_byte", {24'h0, tx_data}, (i == 7) ? 32'hAA : 32'h11 + i);
      cyc(0, 0, 0, 1, 1);
    end
    chk("pp_empty", {31'h0, tx_valid}, 32'h0);

    cyc(1, 32'h0000_2000, 32'h1, 0, 1);
    chk("bus_err_set", {31'h0, bus_err}, 32'h1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    chk("bus_err_sticky", {31'h0, bus_err}, 32'h1);

    for (int i = 0; i < 3; i++) cyc(1, A_TX, 32'h30 + i, 0, 1);
    cyc(1, A_GPIO, 32'h1234, 0, 1);
    cyc(1, A_GPIO, 32'h999, 0, 0);
    chk("mid_rst_valid", {31'h0, tx_valid}, 32'h0);
    chk("mid_rst_gpio", gpio_out, 32'h0);
    chk("mid_rst_berr", {31'h0, bus_err}, 32'h0);
    peek("mid_rst_status", A_STAT, 32'h0000_0001);
    cyc(0, 0, 0, 0, 1);

`ifdef MEMIO_CYCLE_COUNTER_EN
    cyc(1, A_CYC, 32'hFFFF_FFFE, 0, 1);
    peek("cycle_0", A_CYC, 32'hFFFF_FFFE);
    cyc(0, A_CYC, 0, 0, 1);
    peek("cycle_1", A_CYC, 32'hFFFF_FFFF);
    cyc(0, A_CYC, 0, 0, 1);
    peek("cycle_2", A_CYC, 32'h0000_0000);
    chk("cycle_no_berr", {31'h0, bus_err}, 32'h0);
`else
    peek("cycle_absent", A_CYC, 32'h0);
    cyc(1, A_CYC, 32'hFFFF_FFFE, 0, 1);
    chk("cycle_wr_berr", {31'h0, bus_err}, 32'h1);
`endif

    for (int n = 0; n < 2500; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 9))
        0, 1, 2: a = $urandom_range(0, RW * 4 - 1);
        3:       a = A_GPIO | $urandom_range(0, 3);
        4, 5:    a = A_TX;
        6:       a = A_STAT;
        7:       a = A_CYC;
        8:       a = (RW * 4) + $urandom_range(0, 3);
        default: a = ($urandom_range(0, 1) != 0) ? 32'hFFFF_0010 : $urandom;
      endcase
      cyc($urandom_range(0, 1), a,
          ($urandom_range(0, 3) == 0) ? 32'h4 : $urandom,
          $urandom_range(0, 2) == 0, $urandom_range(0, 199) != 0);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Responder side of the core's data-memory port. It services the core's `MemWrite` / `ALUResult` / `WriteData` requests and returns `ReadData` within the same cycle. It holds word RAM plus a small memory-mapped I/O page: GPIO register, byte TX FIFO with valid/ready drain, status and cycle counter. It sits beside the processor at the top level, on the data side only; instruction fetch is not served here.

## Interface
- `RAM_WORDS`, 64: RAM depth in 32-bit words; power of 2, 16–4096.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of 2, 2–64.
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-low; sampled on rising `clk`.
- `MemWrite` input 1: write strobe from core.
- `ALUResult` input 32: byte address from core; bits [1:0] ignored everywhere.
- `WriteData` input 32: store data from core.
- `ReadData` output 32: load data, combinational from `ALUResult`.
- `gpio_out` output 32: GPIO register value.
- `tx_data` output 8: FIFO head byte.
- `tx_valid` output 1: FIFO non-empty.
- `tx_ready` input 1: downstream accepts `tx_data` this cycle.
- `bus_err` output 1: sticky; write to an unmapped address occurred.

## Operation
- Address map (word-aligned):
  - `0x0000_0000` to `RAM_WORDS*4-1`: RAM, R/W.
  - `0xFFFF_0000`: GPIO, R/W.
  - `0xFFFF_0004`: TX push. A write pushes `WriteData[7:0]`. Reads return 0.
  - `0xFFFF_0008`: STATUS.
    - Read: bit0 empty, bit1 full, bit2 overflow (sticky), bits[15:8] occupancy count, all other bits 0.
    - Write: `WriteData[2]=1` clears overflow; other bits are ignored.
  - `0xFFFF_000C`: CYCLE. Read returns the counter; a write loads `WriteData`.
  - All other addresses: read 0. A write is ignored and sets `bus_err`.
- Writes take effect on the rising edge while `MemWrite=1`. Reads see pre-edge state. A read of an address written in the same cycle returns the old value.
- RAM contents are not reset (X after power-up); there is no byte or halfword write.
- TX FIFO:
  - Circular buffer with read/write pointers and count.
  - `tx_valid = (count != 0)`; a pop occurs on an edge where `tx_valid && tx_ready`.
  - Push while full with no pop in the same cycle: the byte is dropped, the FIFO is unchanged and overflow is set.
  - Push while full with a pop in the same cycle: the push is accepted and count is unchanged.
  - Push while empty: `tx_valid` rises the next cycle. There is no fall-through.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `tx_ready` while `tx_valid=0` has no effect.
- Overflow set and clear in the same cycle: set wins.

## Timing
- Reset values (cycle after `reset=0` sampled): `gpio_out=0`, FIFO empty (`tx_valid=0`), overflow 0, CYCLE 0, `bus_err=0`.
  - `tx_data` is don't-care while `tx_valid=0`.
  - `ReadData` reflects post-reset state.
- Reset mid-transfer: FIFO contents are discarded and any pending write that cycle is not performed.
- Load latency 0 cycles (combinational). Store latency 1 edge.
- CYCLE increments by 1 every non-reset cycle and wraps `0xFFFF_FFFF` to `0`. A write loads `WriteData` on that edge, taking priority over the increment; the next edge increments from the loaded value.
- `tx_data` and `tx_valid` change only on clock edges and are registered state.

## Configuration
- `MEMIO_CYCLE_COUNTER_EN`: defined means the 32-bit CYCLE counter is built as above.
- Undefined means no counter flops: `0xFFFF_000C` reads 0 and a write there is treated as unmapped (sets `bus_err`).

## Test plan
- Reset, then write `0xDEADBEEF` to `0x0000_0010`, then read `0x0000_0013` -> `ReadData=0xDEADBEEF`. Write to `0xFFFF_0000` with `0x5A` -> `gpio_out=0x0000_005A` after the edge.
- `tx_ready=0`; push `0x01` through `0x09` (9 writes, `FIFO_DEPTH=8`) -> STATUS reads `0x0000_0806` (count 8, full, overflow). Then `tx_ready=1` -> bytes `0x01` to `0x08` drain in order on consecutive cycles and `tx_valid` falls after the 8th.
- FIFO full and `tx_ready=1`; push `0xAA` in the same cycle -> count stays 8, overflow stays 0, `0xAA` emerges last.
- Write STATUS with `0x4` after overflow -> bit2 clears. Write `0x0000_2000` -> `bus_err=1`, persisting until reset.
- With `MEMIO_CYCLE_COUNTER_EN`: write `0xFFFF_FFFE` to CYCLE, then read on each of the next 3 cycles -> `0xFFFF_FFFE`, `0xFFFF_FFFF`, `0x0000_0000`. Without the macro: the read is 0 and the write sets `bus_err`.
- Assert `reset=0` with 3 bytes queued and GPIO nonzero -> next cycle `tx_valid=0`, `gpio_out=0`, STATUS `0x0000_0001`.
